// File: rtl/oled_pkg.sv
// Shared OLED definitions: SPI writer FSM states, D/C encodings and default SPI timing.
// Used by the OLED init/display FSMs and by oled_spi_writer.
package oled_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    LOW,
    HIGH,
    HOLD,
    DONE
  } oled_spi_state_e;

  localparam logic DC_CMD  = 1'b0;
  localparam logic DC_DATA = 1'b1;

  localparam int DEF_CLK_DIV  = 1;
  localparam int DEF_CS_SETUP = 1;
  localparam int DEF_CS_HOLD  = 1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/oled_spi_writer.sv
// Byte-wide mode-0 SPI transmitter for SSD1306-class OLED panels (SCLK, MOSI, CS#, D/C).
// Define OLED_SPI_LSB_FIRST_EN to shift data[0] first; the default build sends data[7] first.
module oled_spi_writer
  import oled_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int CS_SETUP = DEF_CS_SETUP,
  parameter int CS_HOLD  = DEF_CS_HOLD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena_write,
  input  logic [7:0] data,
  input  logic       oled_dc,
  output logic       write_done,
  output logic       busy,
  output logic       spi_sclk,
  output logic       spi_mosi,
  output logic       spi_cs_n,
  output logic       spi_dc
);

`ifdef OLED_SPI_LSB_FIRST_EN
  localparam bit LSB_FIRST = 1'b1;
`else
  localparam bit LSB_FIRST = 1'b0;
`endif

  localparam int LEAD = LSB_FIRST ? 0 : 7;
  localparam int PH_W = $clog2(max3(CLK_DIV, CS_SETUP, CS_HOLD)) + 1;

  localparam logic [PH_W-1:0] SETUP_LAST = PH_W'(CS_SETUP - 1);
  localparam logic [PH_W-1:0] HALF_LAST  = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0] HOLD_LAST  = PH_W'(CS_HOLD - 1);

  oled_spi_state_e state_q, state_d;
  logic [PH_W-1:0] ph_q, ph_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [7:0]      shreg_next;
  logic            sclk_q, sclk_d;
  logic            mosi_q, mosi_d;
  logic            cs_n_q, cs_n_d;
  logic            dc_q, dc_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;

  // The bit being presented always sits at the LEAD end of the shift register.
  assign shreg_next = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    cs_n_d  = cs_n_q;
    dc_d    = dc_q;
    done_d  = 1'b0;
    busy_d  = busy_q;

    case (state_q)
      IDLE: begin
        if (ena_write) begin
          state_d = SETUP;
          ph_d    = '0;
          bit_d   = 3'd0;
          shreg_d = data;
          mosi_d  = data[LEAD];
          dc_d    = oled_dc;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end

      SETUP: begin
        if (ph_q == SETUP_LAST) begin
          state_d = LOW;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end

      LOW: begin
        if (ph_q == HALF_LAST) begin
          state_d = HIGH;
          ph_d    = '0;
          sclk_d  = 1'b1;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end

      HIGH: begin
        if (ph_q == HALF_LAST) begin
          ph_d   = '0;
          sclk_d = 1'b0;
          if (bit_q == 3'd7) begin
            state_d = HOLD;
          end else begin
            // Next bit goes out on the falling edge, a full half-period before the panel samples it.
            state_d = LOW;
            bit_d   = bit_q + 3'd1;
            shreg_d = shreg_next;
            mosi_d  = shreg_next[LEAD];
          end
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end

      HOLD: begin
        if (ph_q == HOLD_LAST) begin
          state_d = DONE;
          ph_d    = '0;
          cs_n_d  = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ph_q    <= '0;
      bit_q   <= 3'd0;
      shreg_q <= 8'h00;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      dc_q    <= 1'b1;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
      dc_q    <= dc_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign write_done = done_q;
  assign busy       = busy_q;
  assign spi_sclk   = sclk_q;
  assign spi_mosi   = mosi_q;
  assign spi_cs_n   = cs_n_q;
  assign spi_dc     = dc_q;

  // Zero-length phases would wrap the phase counter; catch a bad instantiation early.
  always_ff @(posedge clk) begin
    assert (CLK_DIV >= 1 && CS_SETUP >= 1 && CS_HOLD >= 1)
      else $error("oled_spi_writer: CLK_DIV, CS_SETUP and CS_HOLD must all be >= 1");
  end

endmodule
